calc_seq_alu: RTL and testbench

//  Parametrised multi-cycle calculator core for the board calculator datapath.

---
 rtl/calc_seq_alu_if.sv | 35 +++
 rtl/calc_seq_alu.sv | 193 +++++++++++++++++++
 tb/tb_calc_seq_alu.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/calc_seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : calc_seq_alu_if
// Description : Operation request / result bundle for the calculator core.
//               The master drives the operation request; the slave (core)
//               returns status, the result and the flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface calc_seq_alu_if #(
    parameter int W  = 8,
    parameter int RW = 32
) ();
    logic          start;
    logic          clear;
    logic          chain;
    logic [2:0]    op;
    logic [W-1:0]  num1;
    logic [W-1:0]  num2;
    logic          busy;
    logic          done;
    logic [RW-1:0] result;
    logic          ovf;
    logic          err_div0;

    modport master (
        output start, clear, chain, op, num1, num2,
        input  busy, done, result, ovf, err_div0
    );

    modport slave (
        input  start, clear, chain, op, num1, num2,
        output busy, done, result, ovf, err_div0
    );
endinterface
`default_nettype wire

// File: rtl/calc_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : calc_seq_alu
// Description : Multi-cycle unsigned calculator core. Single-cycle add, sub,
//               load and nop; RW-cycle shift-add multiply/square and
//               restoring divide/modulo. Operand A is num1 or the running
//               accumulator (chain mode). Flags overflow and divide-by-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_seq_alu #(
    parameter int W  = 8,
    parameter int RW = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    calc_seq_alu_if.slave      bus
);
    localparam int CW = $clog2(RW);

    localparam logic [2:0] C_OP_ADD  = 3'b000;
    localparam logic [2:0] C_OP_SUB  = 3'b001;
    localparam logic [2:0] C_OP_MUL  = 3'b010;
    localparam logic [2:0] C_OP_DIV  = 3'b011;
    localparam logic [2:0] C_OP_MOD  = 3'b100;
    localparam logic [2:0] C_OP_SQR  = 3'b101;
    localparam logic [2:0] C_OP_LOAD = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic           r_start_d;
    logic [2:0]     r_op;
    logic [RW-1:0]  r_a;
    logic [RW-1:0]  r_b;
    logic [RW-1:0]  r_hi;      // product high half / division remainder
    logic [RW-1:0]  r_lo;      // multiplier->product low half / dividend->quotient
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic [RW-1:0]  r_result;
    logic           r_ovf;
    logic           r_err;

    logic           w_accept;
    logic [RW-1:0]  w_a_in;
    logic [RW-1:0]  w_b_in;
    logic           w_iterative;
    logic [RW:0]    w_sum;
    logic [RW:0]    w_madd;
    logic [RW:0]    w_shift;
    logic [RW-1:0]  w_trial;
    logic           w_fits;
    logic [RW-1:0]  w_fin_result;
    logic           w_fin_ovf;
    logic           w_fin_err;

    assign w_accept    = (r_state == ST_IDLE) && bus.start && !r_start_d && !bus.clear;
    assign w_a_in      = bus.chain ? r_result : {{(RW-W){1'b0}}, bus.num1};
    assign w_b_in      = {{(RW-W){1'b0}}, bus.num2};
    // Division by zero skips the iteration and finishes immediately.
    assign w_iterative = (bus.op == C_OP_MUL) || (bus.op == C_OP_SQR) ||
                         (((bus.op == C_OP_DIV) || (bus.op == C_OP_MOD)) && (w_b_in != '0));

    // One shift-add step: conditionally add the multiplicand, shift right.
    assign w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    // One restoring-division step: bring in the next dividend bit, try subtract.
    assign w_shift = {r_hi, r_lo[RW-1]};
    assign w_fits  = (w_shift >= {1'b0, r_b});
    assign w_trial = w_shift[RW-1:0] - r_b;
    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};

    // Next-state selection; clear always returns to idle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = w_iterative ? ST_RUN : ST_FIN;
            ST_RUN:  if (r_cnt == CW'(RW-1)) w_state_next = ST_FIN;
            ST_FIN:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (bus.clear) w_state_next = ST_IDLE;
    end

    // Final result and flags committed in the FIN cycle.
    always_comb begin
        w_fin_result = r_result;
        w_fin_ovf    = 1'b0;
        w_fin_err    = 1'b0;
        case (r_op)
            C_OP_ADD: begin
                w_fin_result = w_sum[RW-1:0];
                w_fin_ovf    = w_sum[RW];
            end
            C_OP_SUB: begin
                w_fin_result = r_a - r_b;
                w_fin_ovf    = (r_a < r_b);
            end
            C_OP_MUL, C_OP_SQR: begin
                w_fin_result = r_lo;
                w_fin_ovf    = |r_hi;
            end
            C_OP_DIV: begin
                w_fin_result = (r_b == '0) ? {RW{1'b1}} : r_lo;
                w_fin_err    = (r_b == '0);
            end
            C_OP_MOD: begin
                w_fin_result = (r_b == '0) ? r_a : r_hi;
                w_fin_err    = (r_b == '0);
            end
            C_OP_LOAD: w_fin_result = r_b;
            default:   w_fin_result = r_result;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Operand capture, iteration datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_d <= 1'b0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_start_d <= bus.start;
            r_done    <= 1'b0;
            if (bus.clear) begin
                r_busy   <= 1'b0;
                r_result <= '0;
                r_ovf    <= 1'b0;
                r_err    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_op   <= bus.op;
                            r_a    <= w_a_in;
                            r_b    <= w_b_in;
                            r_hi   <= '0;
                            r_lo   <= (bus.op == C_OP_MUL) ? w_b_in : w_a_in;
                            r_cnt  <= '0;
                            r_busy <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        r_cnt <= r_cnt + CW'(1);
                        if ((r_op == C_OP_MUL) || (r_op == C_OP_SQR)) begin
                            r_hi <= w_madd[RW:1];
                            r_lo <= {w_madd[0], r_lo[RW-1:1]};
                        end else begin
                            r_hi <= w_fits ? w_trial : w_shift[RW-1:0];
                            r_lo <= {r_lo[RW-2:0], w_fits};
                        end
                    end
                    ST_FIN: begin
                        r_result <= w_fin_result;
                        r_ovf    <= w_fin_ovf;
                        r_err    <= w_fin_err;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.ovf      = r_ovf;
    assign bus.err_div0 = r_err;

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_seq_alu
// Description : Directed self-checking bench for calc_seq_alu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_seq_alu;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_MOD  = 3'b100;
    localparam logic [2:0] OP_SQR  = 3'b101;
    localparam logic [2:0] OP_LOAD = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   lat;
    int   dones;

    calc_seq_alu_if #(.W(8), .RW(32)) bus ();

    calc_seq_alu #(.W(8), .RW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one op, scramble inputs after capture, wait for done (bounded).
    task automatic run_op(input logic [2:0] op, input logic chain,
                          input logic [7:0] n1, input logic [7:0] n2, output int latency);
        @(negedge clk);
        bus.op = op; bus.chain = chain; bus.num1 = n1; bus.num2 = n2; bus.start = 1'b1;
        @(posedge clk); #1;
        check_eq("busy_edge0", {63'd0, bus.busy}, 64'd1);
        @(negedge clk);
        bus.start = 1'b0; bus.num1 = ~n1; bus.num2 = ~n2; bus.chain = ~chain; bus.op = OP_ADD;
        latency = 0;
        while (latency < 100) begin
            @(posedge clk); #1;
            latency++;
            if (bus.done) break;
        end
        check_eq("done_seen", {63'd0, bus.done}, 64'd1);
        check_eq("busy_at_done", {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic expect_res(input string tag, input int latency, input int exp_lat,
                              input logic [31:0] res, input logic ovf, input logic err);
        check_eq({tag, "_lat"}, 64'(latency), 64'(exp_lat));
        check_eq({tag, "_res"}, {32'd0, bus.result}, {32'd0, res});
        check_eq({tag, "_ovf"}, {63'd0, bus.ovf}, {63'd0, ovf});
        check_eq({tag, "_err"}, {63'd0, bus.err_div0}, {63'd0, err});
    endtask

    initial begin
        bus.start = 1'b0; bus.clear = 1'b0; bus.chain = 1'b0;
        bus.op = OP_NOP; bus.num1 = '0; bus.num2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", {28'd0, bus.result, bus.busy, bus.done, bus.ovf, bus.err_div0}, 64'd0);
        @(negedge clk); rst = 1'b0;

        // 1: add
        run_op(OP_ADD, 1'b0, 8'h12, 8'h34, lat);
        expect_res("add", lat, 1, 32'h0000_0046, 1'b0, 1'b0);

        // 2: mul, chained squares
        run_op(OP_MUL, 1'b0, 8'hFF, 8'hFF, lat);
        expect_res("mul", lat, 33, 32'h0000_FE01, 1'b0, 1'b0);
        run_op(OP_SQR, 1'b1, 8'h00, 8'h00, lat);
        expect_res("sqr1", lat, 33, 32'hFC05_FC01, 1'b0, 1'b0);
        run_op(OP_SQR, 1'b1, 8'h00, 8'h00, lat);
        expect_res("sqr2", lat, 33, 32'hC81B_F801, 1'b1, 1'b0);

        // 3: div / mod / divide by zero / nop
        run_op(OP_DIV, 1'b0, 8'd200, 8'd7, lat);
        expect_res("div", lat, 33, 32'd28, 1'b0, 1'b0);
        run_op(OP_MOD, 1'b0, 8'd200, 8'd7, lat);
        expect_res("mod", lat, 33, 32'd4, 1'b0, 1'b0);
        run_op(OP_DIV, 1'b0, 8'd200, 8'd0, lat);
        expect_res("div0", lat, 1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_op(OP_MOD, 1'b0, 8'd200, 8'd0, lat);
        expect_res("mod0", lat, 1, 32'd200, 1'b0, 1'b1);
        run_op(OP_NOP, 1'b0, 8'd1, 8'd2, lat);
        expect_res("nop", lat, 1, 32'd200, 1'b0, 1'b0);

        // 4: sub borrow, chained add carry, load
        run_op(OP_SUB, 1'b0, 8'h05, 8'h07, lat);
        expect_res("sub", lat, 1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op(OP_ADD, 1'b1, 8'h00, 8'h03, lat);
        expect_res("addc", lat, 1, 32'h0000_0001, 1'b1, 1'b0);
        run_op(OP_LOAD, 1'b0, 8'h00, 8'h5A, lat);
        expect_res("load", lat, 1, 32'h0000_005A, 1'b0, 1'b0);

        // 5a: start held high launches one op
        @(negedge clk);
        bus.op = OP_ADD; bus.chain = 1'b0; bus.num1 = 8'd1; bus.num2 = 8'd2; bus.start = 1'b1;
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        @(negedge clk); bus.start = 1'b0;
        check_eq("hold_dones", 64'(dones), 64'd1);
        check_eq("hold_res", {32'd0, bus.result}, 64'd3);

        // 5b: extra start pulses while a mul runs are dropped
        bus.op = OP_MUL; bus.num1 = 8'd3; bus.num2 = 8'd5; bus.start = 1'b1;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
            @(negedge clk);
            bus.start = (i == 3) || (i == 10) || (i == 20);
        end
        check_eq("pulse_dones", 64'(dones), 64'd1);
        check_eq("pulse_res", {32'd0, bus.result}, 64'd15);

        // 5c: clear at edge 10 of a mul aborts it
        bus.op = OP_MUL; bus.num1 = 8'd9; bus.num2 = 8'd9; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); bus.clear = 1'b1;
        @(posedge clk); #1;
        check_eq("clr_busy", {63'd0, bus.busy}, 64'd0);
        check_eq("clr_res", {32'd0, bus.result}, 64'd0);
        @(negedge clk); bus.clear = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check_eq("clr_dones", 64'(dones), 64'd0);

        // 6: async reset mid-div
        run_op(OP_LOAD, 1'b0, 8'h00, 8'h77, lat);
        expect_res("load2", lat, 1, 32'h0000_0077, 1'b0, 1'b0);
        @(negedge clk);
        bus.op = OP_DIV; bus.chain = 1'b0; bus.num1 = 8'd200; bus.num2 = 8'd7; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("arst_outs", {28'd0, bus.result, bus.busy, bus.done, bus.ovf, bus.err_div0}, 64'd0);
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check_eq("arst_dones", 64'(dones), 64'd0);
        run_op(OP_ADD, 1'b0, 8'd1, 8'd1, lat);
        expect_res("post_rst", lat, 1, 32'd2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
